// File: rtl/accum_ctrl_fsm_if.sv
// Control-unit <-> datapath/memory signal bundle for the accumulator CPU.
// master = control FSM, slave = datapath side that supplies Opcode and MemReady.
interface accum_ctrl_fsm_if;
  logic [3:0] Opcode;
  logic       MemReady;
  logic       PCWrite;
  logic       Branch;
  logic       bneOrbeq;
  logic [1:0] PCSrc;
  logic       IRWrite;
  logic       IorD;
  logic       MemRead;
  logic       MemWrite;
  logic       ALUSrcA;
  logic [1:0] ALUSrcB;
  logic [1:0] ALUOp;
  logic       ACCWrite;
  logic [1:0] AccSrc;
  logic       Halted;
  logic       Fault;

  modport master (
    input  Opcode, MemReady,
    output PCWrite, Branch, bneOrbeq, PCSrc, IRWrite, IorD, MemRead, MemWrite,
           ALUSrcA, ALUSrcB, ALUOp, ACCWrite, AccSrc, Halted, Fault
  );

  modport slave (
    output Opcode, MemReady,
    input  PCWrite, Branch, bneOrbeq, PCSrc, IRWrite, IorD, MemRead, MemWrite,
           ALUSrcA, ALUSrcB, ALUOp, ACCWrite, AccSrc, Halted, Fault
  );
endinterface

// File: rtl/accum_ctrl_fsm.sv
// Multicycle fetch/decode/execute controller for the 16-bit accumulator CPU,
// with a ready/valid memory handshake, wait timeout, trap and halt.
module accum_ctrl_fsm #(
  parameter int unsigned WAIT_LIMIT      = 15,
  parameter logic [1:0]  TRAP_VECTOR_SEL = 2'b11
) (
  input  logic                  CLK,
  input  logic                  reset,
  accum_ctrl_fsm_if.master      bus
);

  localparam logic [3:0] ST_FETCH  = 4'd0;
  localparam logic [3:0] ST_DECODE = 4'd1;
  localparam logic [3:0] ST_MEM_RD = 4'd2;
  localparam logic [3:0] ST_ALU_WB = 4'd3;
  localparam logic [3:0] ST_ACC_LD = 4'd4;
  localparam logic [3:0] ST_MEM_WR = 4'd5;
  localparam logic [3:0] ST_LDI    = 4'd6;
  localparam logic [3:0] ST_BRANCH = 4'd7;
  localparam logic [3:0] ST_JUMP   = 4'd8;
  localparam logic [3:0] ST_TRAP   = 4'd9;
  localparam logic [3:0] ST_HALT   = 4'd10;

  // Count value seen in the last allowed wait cycle.
  localparam logic [7:0] WAIT_LAST = 8'(WAIT_LIMIT - 1);

  logic [3:0] state_q, state_d;
  logic [7:0] wait_q, wait_d;
  logic       fault_q, fault_d;
  logic       wait_expired;

  logic       pc_write, branch, bne_or_beq, ir_write, i_or_d;
  logic       mem_read, mem_write, alu_src_a, acc_write, halted;
  logic [1:0] pc_src, alu_src_b, alu_op, acc_src;

  assign wait_expired = (wait_q == WAIT_LAST);

  // Next state; wait_d defaults to 0 so any state change clears the counter.
  always_comb begin
    state_d = state_q;
    wait_d  = '0;
    fault_d = fault_q;
    case (state_q)
      ST_FETCH: begin
        if (bus.MemReady)      state_d = ST_DECODE;
        else if (wait_expired) state_d = ST_TRAP;
        else                   wait_d  = wait_q + 8'd1;
      end
      ST_DECODE: begin
        case (bus.Opcode)
          4'h0, 4'h1, 4'h2, 4'h3, 4'h4: state_d = ST_MEM_RD;
          4'h5:                         state_d = ST_MEM_WR;
          4'h6:                         state_d = ST_LDI;
          4'h7, 4'h8:                   state_d = ST_BRANCH;
          4'h9:                         state_d = ST_JUMP;
          4'hF:                         state_d = ST_HALT;
          default:                      state_d = ST_TRAP;
        endcase
      end
      ST_MEM_RD: begin
        if (bus.MemReady)      state_d = (bus.Opcode == 4'h4) ? ST_ACC_LD : ST_ALU_WB;
        else if (wait_expired) state_d = ST_TRAP;
        else                   wait_d  = wait_q + 8'd1;
      end
      ST_MEM_WR: begin
        if (bus.MemReady)      state_d = ST_FETCH;
        else if (wait_expired) state_d = ST_TRAP;
        else                   wait_d  = wait_q + 8'd1;
      end
      ST_ALU_WB, ST_ACC_LD, ST_LDI, ST_BRANCH, ST_JUMP: state_d = ST_FETCH;
      ST_TRAP: begin
        fault_d = 1'b1;
        state_d = ST_FETCH;
      end
      ST_HALT: state_d = ST_HALT;
      default: state_d = ST_FETCH;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!reset) begin
      state_q <= ST_FETCH;
      wait_q  <= '0;
      fault_q <= 1'b0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
      fault_q <= fault_d;
    end
  end

  // Output decode; reset forces everything low regardless of state.
  always_comb begin
    pc_write   = 1'b0;
    branch     = 1'b0;
    bne_or_beq = 1'b0;
    pc_src     = 2'b00;
    ir_write   = 1'b0;
    i_or_d     = 1'b0;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    alu_src_a  = 1'b0;
    alu_src_b  = 2'b00;
    alu_op     = 2'b00;
    acc_write  = 1'b0;
    acc_src    = 2'b00;
    halted     = 1'b0;
    if (reset) begin
      case (state_q)
        ST_FETCH: begin
          mem_read  = 1'b1;
          alu_src_b = 2'b01;
          if (bus.MemReady) begin
            ir_write = 1'b1;
            pc_write = 1'b1;
          end
        end
        ST_DECODE: alu_src_b = 2'b10;
        ST_MEM_RD: begin
          mem_read = 1'b1;
          i_or_d   = 1'b1;
        end
        ST_ALU_WB: begin
          alu_src_a = 1'b1;
          alu_op    = bus.Opcode[1:0];
          acc_write = 1'b1;
        end
        ST_ACC_LD: begin
          acc_write = 1'b1;
          acc_src   = 2'b01;
        end
        ST_MEM_WR: begin
          mem_write = 1'b1;
          i_or_d    = 1'b1;
        end
        ST_LDI: begin
          acc_write = 1'b1;
          acc_src   = 2'b10;
        end
        ST_BRANCH: begin
          branch     = 1'b1;
          pc_src     = 2'b01;
          bne_or_beq = (bus.Opcode == 4'h7);
        end
        ST_JUMP: begin
          pc_write = 1'b1;
          pc_src   = 2'b10;
        end
        ST_TRAP: begin
          pc_write = 1'b1;
          pc_src   = TRAP_VECTOR_SEL;
        end
        ST_HALT: halted = 1'b1;
        default: ;
      endcase
    end
  end

  assign bus.PCWrite  = pc_write;
  assign bus.Branch   = branch;
  assign bus.bneOrbeq = bne_or_beq;
  assign bus.PCSrc    = pc_src;
  assign bus.IRWrite  = ir_write;
  assign bus.IorD     = i_or_d;
  assign bus.MemRead  = mem_read;
  assign bus.MemWrite = mem_write;
  assign bus.ALUSrcA  = alu_src_a;
  assign bus.ALUSrcB  = alu_src_b;
  assign bus.ALUOp    = alu_op;
  assign bus.ACCWrite = acc_write;
  assign bus.AccSrc   = acc_src;
  assign bus.Halted   = halted;
  assign bus.Fault    = reset & fault_q;

endmodule

// File: tb/tb_accum_ctrl_fsm.sv
// Directed-vector bench for accum_ctrl_fsm: stimulus pushes expected output
// vectors into a queue; a negedge monitor pops and compares each cycle.
module tb_accum_ctrl_fsm;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  accum_ctrl_fsm_if bus ();

  accum_ctrl_fsm #(
    .WAIT_LIMIT      (15),
    .TRAP_VECTOR_SEL (2'b11)
  ) dut (
    .CLK   (clk),
    .reset (rst_n),
    .bus   (bus)
  );

  // {PCWrite, Branch, bneOrbeq, PCSrc, IRWrite, IorD, MemRead, MemWrite,
  //  ALUSrcA, ALUSrcB, ALUOp, ACCWrite, AccSrc, Halted, Fault}
  logic [18:0] got;
  assign got = {bus.PCWrite, bus.Branch, bus.bneOrbeq, bus.PCSrc, bus.IRWrite, bus.IorD,
                bus.MemRead, bus.MemWrite, bus.ALUSrcA, bus.ALUSrcB, bus.ALUOp,
                bus.ACCWrite, bus.AccSrc, bus.Halted, bus.Fault};

  typedef struct {
    logic [18:0] exp;
    string       name;
  } exp_t;

  exp_t sb_q[$];
  exp_t mon_e;
  int   n_checks = 0;
  int   n_pass   = 0;
  logic exp_fault = 1'b0;

  function automatic logic [18:0] mk(
    input logic pcw, input logic br, input logic beq, input logic [1:0] pcsrc,
    input logic irw, input logic iord, input logic mr, input logic mw, input logic asa,
    input logic [1:0] asb, input logic [1:0] aop, input logic accw,
    input logic [1:0] accsrc, input logic halt, input logic flt);
    return {pcw, br, beq, pcsrc, irw, iord, mr, mw, asa, asb, aop, accw, accsrc, halt, flt};
  endfunction

  function automatic logic [18:0] e_rst();
    return '0;
  endfunction
  function automatic logic [18:0] e_fwait(input logic f);
    return mk(0, 0, 0, 2'b00, 0, 0, 1, 0, 0, 2'b01, 2'b00, 0, 2'b00, 0, f);
  endfunction
  function automatic logic [18:0] e_frdy(input logic f);
    return mk(1, 0, 0, 2'b00, 1, 0, 1, 0, 0, 2'b01, 2'b00, 0, 2'b00, 0, f);
  endfunction
  function automatic logic [18:0] e_dec(input logic f);
    return mk(0, 0, 0, 2'b00, 0, 0, 0, 0, 0, 2'b10, 2'b00, 0, 2'b00, 0, f);
  endfunction
  function automatic logic [18:0] e_memrd(input logic f);
    return mk(0, 0, 0, 2'b00, 0, 1, 1, 0, 0, 2'b00, 2'b00, 0, 2'b00, 0, f);
  endfunction
  function automatic logic [18:0] e_aluwb(input logic [1:0] op, input logic f);
    return mk(0, 0, 0, 2'b00, 0, 0, 0, 0, 1, 2'b00, op, 1, 2'b00, 0, f);
  endfunction
  function automatic logic [18:0] e_accld(input logic f);
    return mk(0, 0, 0, 2'b00, 0, 0, 0, 0, 0, 2'b00, 2'b00, 1, 2'b01, 0, f);
  endfunction
  function automatic logic [18:0] e_memwr(input logic f);
    return mk(0, 0, 0, 2'b00, 0, 1, 0, 1, 0, 2'b00, 2'b00, 0, 2'b00, 0, f);
  endfunction
  function automatic logic [18:0] e_ldi(input logic f);
    return mk(0, 0, 0, 2'b00, 0, 0, 0, 0, 0, 2'b00, 2'b00, 1, 2'b10, 0, f);
  endfunction
  function automatic logic [18:0] e_branch(input logic beq, input logic f);
    return mk(0, 1, beq, 2'b01, 0, 0, 0, 0, 0, 2'b00, 2'b00, 0, 2'b00, 0, f);
  endfunction
  function automatic logic [18:0] e_jump(input logic f);
    return mk(1, 0, 0, 2'b10, 0, 0, 0, 0, 0, 2'b00, 2'b00, 0, 2'b00, 0, f);
  endfunction
  function automatic logic [18:0] e_trap(input logic f);
    return mk(1, 0, 0, 2'b11, 0, 0, 0, 0, 0, 2'b00, 2'b00, 0, 2'b00, 0, f);
  endfunction
  function automatic logic [18:0] e_halt(input logic f);
    return mk(0, 0, 0, 2'b00, 0, 0, 0, 0, 0, 2'b00, 2'b00, 0, 2'b00, 1, f);
  endfunction

  // One clock cycle of stimulus plus the output expected during that cycle.
  task automatic step(input logic rst, input logic [3:0] op, input logic mr,
                      input logic [18:0] exp, input string name);
    exp_t e;
    @(posedge clk);
    #1;
    rst_n        = rst;
    bus.Opcode   = op;
    bus.MemReady = mr;
    e.exp  = exp;
    e.name = name;
    sb_q.push_back(e);
  endtask

  // Zero-wait instruction starting from FETCH.
  task automatic run_instr(input logic [3:0] op);
    string t;
    t = $sformatf("op%0h", op);
    step(1, op, 1, e_frdy(exp_fault), {t, "_fetch"});
    step(1, op, 1, e_dec(exp_fault), {t, "_decode"});
    case (op)
      4'h0, 4'h1, 4'h2, 4'h3: begin
        step(1, op, 1, e_memrd(exp_fault), {t, "_memrd"});
        step(1, op, 1, e_aluwb(op[1:0], exp_fault), {t, "_aluwb"});
      end
      4'h4: begin
        step(1, op, 1, e_memrd(exp_fault), {t, "_memrd"});
        step(1, op, 1, e_accld(exp_fault), {t, "_accld"});
      end
      4'h5: step(1, op, 1, e_memwr(exp_fault), {t, "_memwr"});
      4'h6: step(1, op, 1, e_ldi(exp_fault), {t, "_ldi"});
      4'h7: step(1, op, 1, e_branch(1'b1, exp_fault), {t, "_beq"});
      4'h8: step(1, op, 1, e_branch(1'b0, exp_fault), {t, "_bne"});
      4'h9: step(1, op, 1, e_jump(exp_fault), {t, "_jump"});
      4'hF: step(1, op, 1, e_halt(exp_fault), {t, "_halt"});
      default: begin
        step(1, op, 1, e_trap(exp_fault), {t, "_trap"});
        exp_fault = 1'b1;
      end
    endcase
  endtask

  always @(negedge clk) begin
    if (sb_q.size() != 0) begin
      mon_e = sb_q.pop_front();
      n_checks++;
      if (got === mon_e.exp) n_pass++;
      else $display("FAIL %s: got %b expected %b at %0t", mon_e.name, got, mon_e.exp, $time);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, %0d/%0d checks passed",
             n_pass, n_checks);
    $fatal(1);
  end

  initial begin
    bus.Opcode   = 4'h0;
    bus.MemReady = 1'b1;

    step(0, 4'h0, 1, e_rst(), "reset0");
    step(0, 4'h0, 1, e_rst(), "reset1");

    for (int op = 0; op < 4; op++) run_instr(4'(op));
    run_instr(4'h4);
    run_instr(4'h6);
    run_instr(4'h7);
    run_instr(4'h8);
    run_instr(4'h9);

    // STA with three wait cycles: request held stable, no trap.
    step(1, 4'h5, 1, e_frdy(exp_fault), "sta_fetch");
    step(1, 4'h5, 1, e_dec(exp_fault), "sta_decode");
    for (int i = 0; i < 3; i++) step(1, 4'h5, 0, e_memwr(exp_fault), "sta_wait");
    step(1, 4'h5, 1, e_memwr(exp_fault), "sta_done");

    // Reset in the middle of a store drops the write strobe.
    step(1, 4'h5, 1, e_frdy(exp_fault), "rstmid_fetch");
    step(1, 4'h5, 1, e_dec(exp_fault), "rstmid_decode");
    step(1, 4'h5, 0, e_memwr(exp_fault), "rstmid_memwr");
    step(0, 4'h5, 0, e_rst(), "rstmid_reset");

    // MemReady on the last allowed wait cycle completes the fetch.
    for (int i = 0; i < 14; i++) step(1, 4'h6, 0, e_fwait(exp_fault), "edge_wait");
    step(1, 4'h6, 1, e_frdy(exp_fault), "edge_ready");
    step(1, 4'h6, 1, e_dec(exp_fault), "edge_decode");
    step(1, 4'h6, 1, e_ldi(exp_fault), "edge_ldi");

    // Fifteen wait cycles then trap; Fault sticks afterwards.
    for (int i = 0; i < 15; i++) step(1, 4'h6, 0, e_fwait(exp_fault), "to_wait");
    step(1, 4'h6, 0, e_trap(exp_fault), "to_trap");
    exp_fault = 1'b1;
    step(1, 4'h6, 0, e_fwait(exp_fault), "to_fault_set");
    run_instr(4'h6);

    step(0, 4'h0, 1, e_rst(), "clr_reset");
    exp_fault = 1'b0;

    // Illegal opcode traps and sets Fault.
    run_instr(4'hA);
    step(1, 4'h0, 0, e_fwait(exp_fault), "illegal_fault");

    // HALT ignores MemReady and only reset leaves it.
    step(1, 4'hF, 1, e_frdy(exp_fault), "halt_fetch");
    step(1, 4'hF, 1, e_dec(exp_fault), "halt_decode");
    for (int i = 0; i < 20; i++) step(1, 4'hF, 1'(i % 2), e_halt(exp_fault), "halt_hold");
    step(0, 4'hF, 1, e_rst(), "halt_reset");
    exp_fault = 1'b0;
    step(1, 4'h0, 1, e_frdy(exp_fault), "after_halt_fetch");

    @(negedge clk);
    #1;
    if (sb_q.size() != 0) begin
      n_checks++;
      $display("FAIL scoreboard_drain: got %0d pending expected 0", sb_q.size());
    end
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
